// File: rtl/connection_block_param.sv
// rtl/connection_block_param.sv - scan-configured connection block with double-buffered select
// Optional feature macro: CB_OUT_REG_EN (adds one flop stage on out)
module connection_block_param #(
   parameter int CHANNEL_ONEWAY_WIDTH = 8,
   parameter int NUM_OUTS             = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_0,
   input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_1,
   input  logic                            scan_in,
   input  logic                            scan_en,
   input  logic                            cfg_load,
   output logic [NUM_OUTS-1:0]             out,
   output logic                            scan_out,
   output logic                            cfg_valid,
   output logic                            cfg_err
);

   localparam int MUX_SIZE = 2 * CHANNEL_ONEWAY_WIDTH / NUM_OUTS;
   localparam int SEL_W    = $clog2(MUX_SIZE);
   localparam int CFG_BITS = NUM_OUTS * SEL_W;
   localparam int CNT_W    = $clog2(CFG_BITS + 1);

   // Track split must be even across outputs and each mux must be a power-of-two size.
   if ((CHANNEL_ONEWAY_WIDTH % NUM_OUTS) != 0 || MUX_SIZE < 2 ||
       (MUX_SIZE & (MUX_SIZE - 1)) != 0) begin : g_bad_cfg
      $error("connection_block_param: illegal CHANNEL_ONEWAY_WIDTH/NUM_OUTS combination");
   end

   typedef enum logic {ST_UNCFG, ST_ACTIVE} state_t;

   state_t              state_q, state_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [CFG_BITS:0]   shift_vec;
   logic [NUM_OUTS-1:0] mux_out;
   logic [NUM_OUTS-1:0] out_d;
   logic                good_commit;
   logic                bad_commit;

   // A commit is only good when a full frame is in the shadow and no shift competes with it.
   assign good_commit = cfg_load && !scan_en && (cnt_q == CNT_W'(CFG_BITS));
   assign bad_commit  = cfg_load && !good_commit;
   assign scan_out    = shadow_q[CFG_BITS-1];
   assign cfg_err     = err_q;

   // Shadow shift, frame counter and commit of shadow into the active select register.
   always_comb begin
      shift_vec = {shadow_q, scan_in};
      shadow_d  = shadow_q;
      active_d  = active_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (scan_en) begin
         shadow_d = shift_vec[CFG_BITS-1:0];
         if (cnt_q != CNT_W'(CFG_BITS)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (good_commit) begin
         active_d = shadow_q;
         cnt_d    = '0;
         err_d    = 1'b0;
      end else if (bad_commit) begin
         err_d = 1'b1;
      end
   end

   // Configuration datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_UNCFG;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and outputs; out stays at zero until a configuration has been committed.
   always_comb begin
      state_d   = state_q;
      cfg_valid = 1'b0;
      case (state_q)
         ST_UNCFG: begin
            if (good_commit) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            cfg_valid = 1'b1;
         end
         default: begin
            state_d = ST_UNCFG;
         end
      endcase
      out_d = cfg_valid ? mux_out : '0;
   end

   // Per-output mux: even inputs come from tracks_0, odd inputs from tracks_1, strided by NUM_OUTS.
   always_comb begin
      mux_out = '0;
      for (int k = 0; k < NUM_OUTS; k++) begin
         for (int i = 0; i < MUX_SIZE / 2; i++) begin
            if (active_q[k*SEL_W +: SEL_W] == SEL_W'(2 * i)) begin
               mux_out[k] = tracks_0[k + i*NUM_OUTS];
            end
            if (active_q[k*SEL_W +: SEL_W] == SEL_W'(2 * i + 1)) begin
               mux_out[k] = tracks_1[k + i*NUM_OUTS];
            end
         end
      end
   end

`ifdef CB_OUT_REG_EN
   logic [NUM_OUTS-1:0] out_q;

   // Output retiming stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;
`else
   assign out = out_d;
`endif

endmodule

// File: tb/tb_connection_block_param.sv
// tb/tb_connection_block_param.sv - directed bench for connection_block_param
module tb_connection_block_param;

   localparam int W = 4;
   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] tracks_0;
   logic [W-1:0] tracks_1;
   logic         scan_in;
   logic         scan_en;
   logic         cfg_load;
   logic [N-1:0] out;
   logic         scan_out;
   logic         cfg_valid;
   logic         cfg_err;

   int n_pass  = 0;
   int n_total = 0;

   connection_block_param #(
      .CHANNEL_ONEWAY_WIDTH(W),
      .NUM_OUTS(N)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tracks_0(tracks_0),
      .tracks_1(tracks_1),
      .scan_in(scan_in),
      .scan_en(scan_en),
      .cfg_load(cfg_load),
      .out(out),
      .scan_out(scan_out),
      .cfg_valid(cfg_valid),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic shift(input logic b);
      scan_en = 1'b1;
      scan_in = b;
      cyc();
      scan_en = 1'b0;
      scan_in = 1'b0;
   endtask

   task automatic commit();
      cfg_load = 1'b1;
      cyc();
      cfg_load = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      tracks_0 = 4'b0000;
      tracks_1 = 4'b1111;
      scan_in  = 1'b0;
      scan_en  = 1'b0;
      cfg_load = 1'b0;
      #12;
      chk("rst_out",       {6'd0, out}, 8'h00);
      chk("rst_cfg_valid", {7'd0, cfg_valid}, 8'h00);
      chk("rst_cfg_err",   {7'd0, cfg_err}, 8'h00);
      chk("rst_scan_out",  {7'd0, scan_out}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // frame 1,1,0,1 -> active 1101
      shift(1'b1); shift(1'b1); shift(1'b0); shift(1'b1);
      chk("pre_commit_valid", {7'd0, cfg_valid}, 8'h00);
      chk("pre_commit_out",   {6'd0, out}, 8'h00);
      chk("scan_out_first",   {7'd0, scan_out}, 8'h01);
      commit();
      cyc();
      chk("good1_valid", {7'd0, cfg_valid}, 8'h01);
      chk("good1_err",   {7'd0, cfg_err}, 8'h00);
      chk("good1_out",   {6'd0, out}, 8'h03);
      tracks_0 = 4'b1111; tracks_1 = 4'b0000;
      cyc();
      chk("good1_out_b", {6'd0, out}, 8'h00);
      tracks_0 = 4'b0000; tracks_1 = 4'b1000;
      cyc();
      chk("good1_out_c", {6'd0, out}, 8'h02);

      // short frame: 3 bits then commit is rejected
      shift(1'b0); shift(1'b1); shift(1'b0);
      commit();
      cyc();
      chk("short_err",   {7'd0, cfg_err}, 8'h01);
      chk("short_valid", {7'd0, cfg_valid}, 8'h01);
      chk("short_out",   {6'd0, out}, 8'h02);
      // fourth bit completes frame 0,1,0,0 -> active 0100
      shift(1'b0);
      commit();
      cyc();
      chk("good2_err", {7'd0, cfg_err}, 8'h00);
      tracks_0 = 4'b0001; tracks_1 = 4'b0010;
      cyc();
      chk("good2_out_a", {6'd0, out}, 8'h03);
      tracks_0 = 4'b0000;
      cyc();
      chk("good2_out_b", {6'd0, out}, 8'h02);

      // new frame 1,0,1,1 shifted in ACTIVE without commit; scan_out replays old bits
      shift(1'b1); chk("replay0", {7'd0, scan_out}, 8'h01);
      shift(1'b0); chk("replay1", {7'd0, scan_out}, 8'h00);
      shift(1'b1); chk("replay2", {7'd0, scan_out}, 8'h00);
      shift(1'b1); chk("replay3", {7'd0, scan_out}, 8'h01);
      chk("shadow_only_out", {6'd0, out}, 8'h02);

      // commit together with a shift is rejected (shadow becomes 0110)
      tracks_0 = 4'b0100;
      cyc();
      chk("pre_collide_out", {6'd0, out}, 8'h02);
      cfg_load = 1'b1; scan_en = 1'b1; scan_in = 1'b0;
      cyc();
      cfg_load = 1'b0; scan_en = 1'b0;
      cyc();
      chk("collide_err", {7'd0, cfg_err}, 8'h01);
      chk("collide_out", {6'd0, out}, 8'h02);
      // cfg_load held two cycles: first good (active 0110), second finds cnt=0
      cfg_load = 1'b1;
      cyc();
      chk("held_first_err", {7'd0, cfg_err}, 8'h00);
      cyc();
      cfg_load = 1'b0;
      cyc();
      chk("held_second_err", {7'd0, cfg_err}, 8'h01);
      chk("held_out",        {6'd0, out}, 8'h03);

      // asynchronous reset in the middle of a frame
      shift(1'b1); shift(1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out",   {6'd0, out}, 8'h00);
      chk("mid_rst_valid", {7'd0, cfg_valid}, 8'h00);
      chk("mid_rst_err",   {7'd0, cfg_err}, 8'h00);
      chk("mid_rst_scan",  {7'd0, scan_out}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tracks_0 = 4'b0000; tracks_1 = 4'b1111;
      shift(1'b1); shift(1'b1);
      commit();
      cyc();
      chk("post_rst_err",   {7'd0, cfg_err}, 8'h01);
      chk("post_rst_valid", {7'd0, cfg_valid}, 8'h00);
      chk("post_rst_out",   {6'd0, out}, 8'h00);
      shift(1'b0); shift(1'b1);
      commit();
      cyc();
      chk("post_rst_good_err", {7'd0, cfg_err}, 8'h00);
      chk("post_rst_good_out", {6'd0, out}, 8'h03);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/connection_block_param.md
CONNECTION_BLOCK_PARAM -- requirements
Module: connection_block_param

Interface
REQ-001 SHALL have parameter CHANNEL_ONEWAY_WIDTH, default 8: number of tracks in each direction.
REQ-002 SHALL have parameter NUM_OUTS, default 2: number of block outputs.
REQ-003 SHALL derive localparams:
- MUX_SIZE = 2*CHANNEL_ONEWAY_WIDTH/NUM_OUTS
- SEL_W = clog2(MUX_SIZE)
- CFG_BITS = NUM_OUTS*SEL_W
- CNT_W = clog2(CFG_BITS+1)
REQ-004 SHALL reject at elaboration any configuration where CHANNEL_ONEWAY_WIDTH mod NUM_OUTS != 0 or MUX_SIZE is not a power of 2 and >=2.
REQ-005 SHALL have the following ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- tracks_0  in  CHANNEL_ONEWAY_WIDTH  leftward tracks
- tracks_1  in  CHANNEL_ONEWAY_WIDTH  rightward tracks
- scan_in  in  1  config serial data
- scan_en  in  1  shift enable
- cfg_load  in  1  single-cycle commit request
- out  out  NUM_OUTS  routed track values
- scan_out  out  1  serial chain output
- cfg_valid  out  1  active config committed
- cfg_err  out  1  sticky bad-commit flag

Function
REQ-006 SHALL connect out[k] to a MUX_SIZE:1 mux whose input 2*i is tracks_0[k+i*NUM_OUTS] and input 2*i+1 is tracks_1[k+i*NUM_OUTS], for i in 0..MUX_SIZE/2-1.
REQ-007 SHALL select out[k] by active[(k+1)*SEL_W-1 : k*SEL_W].
REQ-008 SHALL shift on each rising clk with scan_en=1: shadow <= {shadow[CFG_BITS-2:0], scan_in}.
REQ-009 SHALL drive scan_out = shadow[CFG_BITS-1] combinationally.
REQ-010 SHALL increment bit counter cnt on each shift, saturating at CFG_BITS.
REQ-011 SHALL run a two-state FSM:
- UNCFG: cfg_valid=0, out forced to all zeros.
- ACTIVE: cfg_valid=1, out driven by muxes.
REQ-012 SHALL treat cfg_load=1, scan_en=0, cnt==CFG_BITS as a good commit. On the next edge: active <= shadow, cnt <= 0, cfg_err <= 0, FSM -> ACTIVE.
REQ-013 SHALL treat cfg_load=1 with cnt!=CFG_BITS, or with scan_en=1 in the same cycle, as a bad commit. On the next edge: cfg_err <= 1; active, cnt and FSM state unchanged; any shift that cycle still occurs.
REQ-014 SHALL keep shadow shifting in ACTIVE without disturbing active or out until the next good commit (double-buffered reconfiguration).
REQ-015 SHALL hold cfg_err high until a good commit or reset.
REQ-016 SHALL treat cfg_load held high for several cycles as a commit evaluation on every such cycle.

Reset
REQ-017 SHALL on rst_n=0, immediately and independent of clk, clear:
- shadow=0, active=0, cnt=0
- FSM=UNCFG, cfg_valid=0, cfg_err=0
- out=0, scan_out=0
REQ-018 SHALL discard a partially shifted frame on reset mid-shift; the post-reset commit requires a fresh CFG_BITS shifts.
REQ-019 SHALL leave the chain usable on the first clk edge after rst_n deasserts.

Configuration
REQ-020 SHALL, with macro CB_OUT_REG_EN defined, register out through a flop stage reset to 0 by rst_n, giving one clk of latency from tracks or active change to out.
REQ-021 SHALL, with CB_OUT_REG_EN undefined, drive out combinationally from tracks and active with zero latency.

Verification
REQ-022 Use W=4, NUM_OUTS=2 (CFG_BITS=4). Bench SHALL cover:
- Reset only -> out=00, cfg_valid=0, cfg_err=0.
- Shift 1,1,0,1 (first bit first), then cfg_load -> active=4'b1101, cfg_valid=1.
  - tracks_0=4'b0000, tracks_1=4'b1111 -> out[0]=tracks_1[0]=1, out[1]=tracks_1[3]=1.
- Shift 3 bits then cfg_load -> cfg_err=1, cfg_valid and out unchanged.
  - One more shift then cfg_load -> cfg_err=0, new config active.
- In ACTIVE, shift a new frame without cfg_load -> out unchanged.
  - scan_out replays the old frame bits 4 cycles after they entered.
- cfg_load and scan_en together with cnt=4 -> cfg_err=1, active unchanged.
- rst_n pulsed low mid-shift -> all outputs 0 immediately.
  - Commit after 2 shifts -> cfg_err=1.
